// File: rtl/ram_seq_master_pkg.sv
// Shared definitions for the sequence-recording RAM master:
// default geometry, address/length widths, FSM state codes and a
// small length/index increment helper.
package ram_seq_master_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int WIDTH_DEF = 4;
    localparam int ADDR_W    = 4;
    localparam int LEN_W     = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_WAIT_Q = 3'd3;
    localparam logic [2:0] ST_CMP    = 3'd4;

    // Lengths and indices are kept one bit wider than the RAM address so
    // that a full sequence of 16 entries is representable and never wraps.
    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] v);
        return v + 5'd1;
    endfunction

endpackage

// File: rtl/ram_seq_master_ram.sv
// Single-port synchronous RAM, 16 words of 4 bits. Read data is registered
// and valid one cycle after the address is sampled; the array itself has no
// reset, so stored contents survive a reset of the sequencer.
module sync_ram_16x4_file
    import ram_seq_master_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wdata,
    output logic [3:0]        q
);

    logic [3:0] mem_r [0:15];
    logic [3:0] q_r;

    assign q = q_r;

    // Write port and registered read port sharing one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        q_r <= mem_r[addr];
    end

endmodule

// File: rtl/ram_seq_master.sv
// Records a sequence of entries into an external synchronous RAM and later
// compares a stream of player entries against that stored sequence, raising
// hit / miss / done pulses. All outputs come straight from registers.
module ram_seq_master
    import ram_seq_master_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              append,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              clear,
    input  logic              start_cmp,
    input  logic              play_valid,
    input  logic [WIDTH-1:0]  play_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_data,
    input  logic [WIDTH-1:0]  ram_q,
    output logic [LEN_W-1:0]  length,
    output logic              full,
    output logic              busy,
    output logic              hit,
    output logic              miss,
    output logic              done
);

    logic [2:0]        state_r,    state_s;
    logic [LEN_W-1:0]  length_r,   length_s;
    logic [LEN_W-1:0]  index_r,    index_s;
    logic              ram_we_r,   ram_we_s;
    logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
    logic [WIDTH-1:0]  ram_data_r, ram_data_s;
    logic              hit_r,      hit_s;
    logic              miss_r,     miss_s;
    logic              done_r,     done_s;
    logic              full_s;
    logic              last_s;
    logic [LEN_W-1:0]  idx_inc_s;

    assign full_s    = (length_r == LEN_W'(DEPTH));
    assign idx_inc_s = len_inc(index_r);
    // Only meaningful in CMP, where length is always at least 1.
    assign last_s    = (index_r == (length_r - 5'd1));

    assign ram_we   = ram_we_r;
    assign ram_addr = ram_addr_r;
    assign ram_data = ram_data_r;
    assign length   = length_r;
    assign full     = full_s;
    assign busy     = (state_r != ST_IDLE);
    assign hit      = hit_r;
    assign miss     = miss_r;
    assign done     = done_r;

    // Next-state and next-output decode for the sequencer FSM.
    always_comb begin
        state_s    = state_r;
        length_s   = length_r;
        index_s    = index_r;
        ram_we_s   = 1'b0;
        ram_addr_s = ram_addr_r;
        ram_data_s = ram_data_r;
        hit_s      = 1'b0;
        miss_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    length_s = 5'd0;
                end else if (start_cmp) begin
                    if (length_r == 5'd0) begin
                        // An empty sequence is trivially matched.
                        done_s = 1'b1;
                    end else begin
                        index_s    = 5'd0;
                        ram_addr_s = 4'd0;
                        state_s    = ST_FETCH;
                    end
                end else if (append && !full_s) begin
                    ram_we_s   = 1'b1;
                    ram_addr_s = length_r[ADDR_W-1:0];
                    ram_data_s = data_in;
                    state_s    = ST_WRITE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                length_s = len_inc(length_r);
                state_s  = ST_IDLE;
            end
            ST_FETCH: begin
                state_s = ST_WAIT_Q;
            end
            ST_WAIT_Q: begin
                state_s = ST_CMP;
            end
            ST_CMP: begin
                if (play_valid) begin
                    if (play_data == ram_q) begin
                        hit_s = 1'b1;
                        if (last_s) begin
                            done_s  = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            index_s    = idx_inc_s;
                            ram_addr_s = idx_inc_s[ADDR_W-1:0];
                            state_s    = ST_FETCH;
                        end
                    end else begin
                        miss_s  = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_CMP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            length_r   <= 5'd0;
            index_r    <= 5'd0;
            ram_we_r   <= 1'b0;
            ram_addr_r <= 4'd0;
            ram_data_r <= {WIDTH{1'b0}};
            hit_r      <= 1'b0;
            miss_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            length_r   <= length_s;
            index_r    <= index_s;
            ram_we_r   <= ram_we_s;
            ram_addr_r <= ram_addr_s;
            ram_data_r <= ram_data_s;
            hit_r      <= hit_s;
            miss_r     <= miss_s;
            done_r     <= done_s;
        end
    end

endmodule

// File: tb/tb_ram_seq_master.sv
// Bench for ram_seq_master connected to sync_ram_16x4_file. A sequence-level
// model (array of stored values plus a length) predicts lengths, RAM contents
// and hit/miss/done counts for directed and random operations.
module tb_ram_seq_master;

    logic       clk;
    logic       reset_n;
    logic       append;
    logic [3:0] data_in;
    logic       clear;
    logic       start_cmp;
    logic       play_valid;
    logic [3:0] play_data;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [3:0] ram_data;
    logic [3:0] ram_q;
    logic [4:0] length;
    logic       full;
    logic       busy;
    logic       hit;
    logic       miss;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;

    logic [3:0] m_mem [0:15];
    int         m_len;
    logic [3:0] play_q [$];

    ram_seq_master #(.DEPTH(16), .WIDTH(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .append(append), .data_in(data_in),
        .clear(clear), .start_cmp(start_cmp), .play_valid(play_valid),
        .play_data(play_data), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_q(ram_q), .length(length), .full(full),
        .busy(busy), .hit(hit), .miss(miss), .done(done)
    );

    sync_ram_16x4_file u_ram (
        .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_data), .q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with the RAM write enable high.
    initial begin
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) we_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_len = 0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_len = 0;
        check("clear_len", 32'(length), 32'd0);
    endtask

    task automatic do_append(input logic [3:0] v);
        int prev;
        prev    = m_len;
        append  = 1'b1;
        data_in = v;
        tick();
        append  = 1'b0;
        check("append_we", 32'(ram_we), (prev < 16) ? 32'd1 : 32'd0);
        if (prev < 16) begin
            check("append_addr", 32'(ram_addr), 32'(prev));
            check("append_data", 32'(ram_data), 32'(v));
        end
        tick();
        check("append_we_off", 32'(ram_we), 32'd0);
        if (prev < 16) begin
            m_mem[prev] = v;
            m_len = prev + 1;
        end
        check("append_len", 32'(length), 32'(m_len));
        check("append_full", 32'(full), (m_len == 16) ? 32'd1 : 32'd0);
    endtask

    // Plays the entries in play_q; expectations derive from the model only.
    task automatic run_cmp(input string tag);
        int  eh, em, ed, gh, gm, gd;
        bit  got;
        eh = 0; em = 0; ed = 0; gh = 0; gm = 0; gd = 0;
        if (m_len == 0) begin
            ed = 1;
        end else begin
            for (int i = 0; i < play_q.size() && i < m_len; i++) begin
                if (play_q[i] == m_mem[i]) begin
                    eh++;
                    if (i == m_len - 1) begin
                        ed = 1;
                        break;
                    end
                end else begin
                    em = 1;
                    break;
                end
            end
        end
        start_cmp = 1'b1;
        tick();
        start_cmp = 1'b0;
        gh += int'(hit); gm += int'(miss); gd += int'(done);
        if (m_len > 0) begin
            for (int i = 0; i < play_q.size(); i++) begin
                play_valid = 1'b1;
                play_data  = play_q[i];
                got = 1'b0;
                for (int c = 0; c < 8 && !got; c++) begin
                    tick();
                    gh += int'(hit); gm += int'(miss); gd += int'(done);
                    if (hit || miss) got = 1'b1;
                end
                check({tag, "_timeout"}, 32'(got), 32'd1);
                play_valid = 1'b0;
                if (!got || miss || done) break;
            end
        end
        tick();
        gh += int'(hit); gm += int'(miss); gd += int'(done);
        check({tag, "_hits"}, 32'(gh), 32'(eh));
        check({tag, "_miss"}, 32'(gm), 32'(em));
        check({tag, "_done"}, 32'(gd), 32'(ed));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_len"}, 32'(length), 32'(m_len));
    endtask

    typedef struct {
        logic [3:0] val;
        int         exp_len;
        logic       exp_full;
    } app_vec_t;

    app_vec_t   tab [3];
    int         we0;
    logic [3:0] tmp;
    logic [3:0] v15;

    initial begin
        tab[0] = '{4'h3, 1, 1'b0};
        tab[1] = '{4'h7, 2, 1'b0};
        tab[2] = '{4'hA, 3, 1'b0};
        append = 1'b0; data_in = 4'd0; clear = 1'b0; start_cmp = 1'b0;
        play_valid = 1'b0; play_data = 4'd0; reset_n = 1'b0;
        tick();
        do_reset();

        // Reset state
        check("rst_len", 32'(length), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_data", 32'(ram_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_pulses", {29'd0, hit, miss, done}, 32'd0);

        // Table-driven appends 3,7,A
        we0 = we_cnt;
        for (int i = 0; i < 3; i++) begin
            do_append(tab[i].val);
            check("tab_len", 32'(length), 32'(tab[i].exp_len));
            check("tab_full", 32'(full), 32'(tab[i].exp_full));
        end
        check("tab_we_cycles", 32'(we_cnt - we0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("tab_ram", 32'(u_ram.mem_r[i]), 32'(tab[i].val));
        end

        // Full match, then mismatch on second entry
        play_q = '{4'h3, 4'h7, 4'hA};
        run_cmp("match3");
        play_q = '{4'h3, 4'h5};
        run_cmp("miss2");

        // Seventeen appends: the last one is ignored
        do_clear();
        we0 = we_cnt;
        for (int i = 0; i < 17; i++) begin
            tmp = 4'((i * 5 + 2) % 16);
            if (i == 15) v15 = tmp;
            do_append(tmp);
        end
        check("fill_len", 32'(length), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_we_cycles", 32'(we_cnt - we0), 32'd16);
        check("fill_ram15", 32'(u_ram.mem_r[15]), 32'(v15));

        // clear beats start_cmp, then an empty compare finishes at once
        clear = 1'b1; start_cmp = 1'b1;
        tick();
        clear = 1'b0; start_cmp = 1'b0;
        m_len = 0;
        check("clr_cmp_len", 32'(length), 32'd0);
        check("clr_cmp_busy", 32'(busy), 32'd0);
        check("clr_cmp_done", 32'(done), 32'd0);
        start_cmp = 1'b1;
        tick();
        start_cmp = 1'b0;
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        tick();
        check("empty_done_pulse", 32'(done), 32'd0);

        // Append ignored while busy, then reset in CMP
        do_append(4'h1);
        do_append(4'h2);
        start_cmp = 1'b1;
        tick();
        start_cmp = 1'b0;
        append = 1'b1; data_in = 4'hF;
        tick();
        tick();
        append = 1'b0;
        check("busy_cmp", 32'(busy), 32'd1);
        check("busy_append_len", 32'(length), 32'd2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_len = 0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_len", 32'(length), 32'd0);
        check("midrst_we", 32'(ram_we), 32'd0);
        check("midrst_pulses", {29'd0, hit, miss, done}, 32'd0);

        // Random operations against the sequence model
        for (int n = 0; n < 60; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                do_clear();
            end else if (op <= 5) begin
                do_append(4'($urandom_range(0, 15)));
            end else begin
                int k;
                play_q = {};
                k = -1;
                if (m_len > 0 && ($urandom_range(0, 2) == 0)) k = int'($urandom_range(0, m_len - 1));
                for (int i = 0; i < m_len; i++) begin
                    if (i == k) begin
                        play_q.push_back(m_mem[i] ^ 4'($urandom_range(1, 15)));
                        break;
                    end
                    play_q.push_back(m_mem[i]);
                end
                run_cmp("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_seq_master.md
RAM_SEQ_MASTER -- requirements
Module: ram_seq_master

Interface
REQ-001 Parameter: DEPTH, default 16, number of RAM words (address width 4).
REQ-002 Parameter: WIDTH, default 4, RAM data width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 append  in  1  single-cycle request to store data_in at the next sequence position.
REQ-007 data_in  in  4  value to store.
REQ-008 clear  in  1  empty the stored sequence (length to 0; RAM contents untouched).
REQ-009 start_cmp  in  1  start comparing player entries against the stored sequence.
REQ-010 play_valid  in  1  play_data holds a valid player entry this cycle.
REQ-011 play_data  in  4  player entry.
REQ-012 ram_we  out  1  RAM write enable.
REQ-013 ram_addr  out  4  RAM address.
REQ-014 ram_data  out  4  RAM write data.
REQ-015 ram_q  in  4  RAM read data, valid one cycle after ram_addr is sampled.
REQ-016 length  out  5  stored entries, 0..16.
REQ-017 full  out  1  length == 16.
REQ-018 busy  out  1  state not IDLE.
REQ-019 hit  out  1  one-cycle pulse: entry matched.
REQ-020 miss  out  1  one-cycle pulse: entry mismatched; comparison aborted.
REQ-021 done  out  1  one-cycle pulse: all length entries matched.

Function
REQ-022 States: IDLE, WRITE, FETCH, WAIT_Q, CMP; registered state, one transition per cycle maximum.
REQ-023 IDLE + append + !full: ram_addr=length[3:0], ram_data=data_in, ram_we=1 for exactly one cycle (WRITE), then length+1, return to IDLE; 2 cycles total.
REQ-024 append while full SHALL be ignored (no write, length stays 16).
REQ-025 append in any state other than IDLE SHALL be ignored.
REQ-026 Priority in IDLE: clear > start_cmp > append.
REQ-027 clear in IDLE: length<=0 next cycle; ignored outside IDLE.
REQ-028 start_cmp with length==0: done pulses the next cycle; stay in IDLE.
REQ-029 start_cmp with length>0: index<=0, go to FETCH.
REQ-030 FETCH: ram_addr=index, ram_we=0; next state WAIT_Q (RAM captures address).
REQ-031 WAIT_Q: one cycle; ram_q becomes valid; next state CMP.
REQ-032 CMP: wait indefinitely for play_valid; ram_addr held at index.
REQ-033 CMP + play_valid + play_data==ram_q: hit=1; if index==length-1, done=1 in the same cycle and go to IDLE; else index+1 and go to FETCH.
REQ-034 CMP + play_valid + mismatch: miss=1, go to IDLE; length preserved.
REQ-035 play_valid outside CMP SHALL be ignored.
REQ-036 ram_we SHALL be 1 only in WRITE; ram_addr/ram_data hold last values otherwise.
REQ-037 Index arithmetic 5-bit internally; ram_addr = low 4 bits; length==16 never wraps to 0.

Reset
REQ-038 reset_n low at an edge: state=IDLE, length=0, index=0, ram_we=0, ram_addr=0, ram_data=0, hit=miss=done=0.
REQ-039 Reset mid-WRITE or mid-compare SHALL abort immediately; an in-flight write is not guaranteed but ram_we is 0 from the next cycle.

Structure
REQ-040 Shared package: state encoding constants, DEPTH/WIDTH defaults, ADDR_W=4, LEN_W=5.
REQ-041 One natural sub-module: sync_ram_16x4_file instantiated only in the bench/top, not inside this block.
REQ-042 Outputs hit/miss/done/ram_we SHALL be registered or decoded only from registered state (no input-to-output combinational path except CMP compare pulses).

Verification (bench connects ram_seq_master to sync_ram_16x4_file)
REQ-043 Reset, append 3,7,A -> length=3, RAM[0..2]=3,7,A, ram_we high exactly 3 single cycles.
REQ-044 start_cmp, play 3,7,A -> three hit pulses, done on third, busy low after, length stays 3.
REQ-045 start_cmp, play 3,5 -> one hit, miss on second entry, return to IDLE, length=3.
REQ-046 Append 17 values -> length=16, full=1, 17th append ignored, RAM[15]=16th value.
REQ-047 clear and start_cmp asserted together in IDLE -> length=0, no compare; subsequent start_cmp -> done next cycle.
REQ-048 reset_n low during CMP -> next cycle IDLE, length=0, all pulses 0, ram_we=0.
